// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : majority-sampled UART receiver with FWFT receive FIFO     |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int BAUD_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [3:0]        DataLenLimit,
  input  logic              StopLenLimit,
  input  logic              ParityEn,
  input  logic              ParityPolarity,
  input  logic [BAUD_W-1:0] BaudLimit,
  input  logic              Rxd,
  input  logic              RdEn,
  output logic [8:0]        RdData,
  output logic              RdParityErr,
  output logic              RdFrameErr,
  output logic              RdBreak,
  output logic              FifoEmpty,
  output logic              FifoFull,
  output logic [CNT_W-1:0]  FifoCount,
  output logic              Overrun,
  input  logic              OverrunClr,
  output logic              RxBusy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_PUSH    = 3'd5,
    S_BRKWAIT = 3'd6
  } state_t;

  state_t            state;
  logic              sync1, rs, rs_d;
  logic [BAUD_W-1:0] cnt;
  logic [2:0]        samp;
  logic [3:0]        bit_idx;
  logic              stop_idx;
  logic [8:0]        data;
  logic              par_bit, par_err, frame_err, brk;
  logic              maj, bit_tick, sample_pt, in_bit;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) {sync1, rs, rs_d} <= 3'b111;
    else        {sync1, rs, rs_d} <= {Rxd, sync1, rs};
  end

  assign maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
  assign in_bit    = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
  assign bit_tick  = in_bit && (cnt == BaudLimit - BAUD_W'(1));
  assign sample_pt = (cnt == BAUD_W'(1)) || (cnt == '0) || (cnt == BaudLimit);
  assign RxBusy    = (state != S_IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      samp      <= 3'b111;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      data      <= '0;
      par_bit   <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      brk       <= 1'b0;
    end else begin
      if (in_bit) begin
        cnt <= (cnt == '0) ? BaudLimit : cnt - BAUD_W'(1);
        if (sample_pt) samp <= {samp[1:0], rs};
      end
      case (state)
        S_IDLE: begin
          if (Enable && rs_d && !rs) begin
            state     <= S_START;
            cnt       <= BaudLimit >> 1;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            data      <= '0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            brk       <= 1'b0;
          end
        end
        S_START: if (bit_tick) state <= maj ? S_IDLE : S_DATA;
        S_DATA: begin
          if (bit_tick) begin
            data[bit_idx] <= maj;
            bit_idx       <= bit_idx + 4'd1;
            if (bit_idx == DataLenLimit) state <= ParityEn ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            par_bit <= maj;
            par_err <= (^data) ^ maj ^ ParityPolarity;
            state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (!maj) begin
              // A break is an all-zero frame whose first stop bit is also low.
              frame_err <= 1'b1;
              brk       <= !stop_idx && (data == '0) && (!ParityEn || !par_bit);
              state     <= S_PUSH;
            end else if (stop_idx == StopLenLimit) begin
              state <= S_PUSH;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        S_PUSH:    state <= brk ? S_BRKWAIT : S_IDLE;
        S_BRKWAIT: if (rs) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  logic [11:0]      mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, empty, full, do_wr, do_rd;
  logic [11:0]      head;

  assign push  = (state == S_PUSH);
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign do_rd = RdEn && !empty;
  // A full FIFO still accepts the frame when the head is popped in the same cycle.
  assign do_wr = push && (!full || RdEn);

  always_ff @(posedge Clock) begin
    if (do_wr) mem[wr_ptr] <= {brk, frame_err, par_err, data};
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      Overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
      if (push && !do_wr) Overrun <= 1'b1;
      else if (OverrunClr) Overrun <= 1'b0;
    end
  end

  assign head        = empty ? 12'd0 : mem[rd_ptr];
  assign RdData      = head[8:0];
  assign RdParityErr = head[9];
  assign RdFrameErr  = head[10];
  assign RdBreak     = head[11];
  assign FifoEmpty   = empty;
  assign FifoFull    = full;
  assign FifoCount   = count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_fifo : directed self-checking bench for uart_rx_fifo          |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 16;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic [3:0]  DataLenLimit = 4'd7;
  logic        StopLenLimit = 1'b0;
  logic        ParityEn = 1'b0;
  logic        ParityPolarity = 1'b0;
  logic [15:0] BaudLimit = 16'd15;
  logic        Rxd = 1'b1;
  logic        RdEn = 1'b0;
  logic        OverrunClr = 1'b0;
  logic [8:0]  RdData;
  logic        RdParityErr, RdFrameErr, RdBreak;
  logic        FifoEmpty, FifoFull, Overrun, RxBusy;
  logic [2:0]  FifoCount;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(.BAUD_W(16), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable),
    .DataLenLimit(DataLenLimit), .StopLenLimit(StopLenLimit),
    .ParityEn(ParityEn), .ParityPolarity(ParityPolarity),
    .BaudLimit(BaudLimit), .Rxd(Rxd), .RdEn(RdEn),
    .RdData(RdData), .RdParityErr(RdParityErr), .RdFrameErr(RdFrameErr),
    .RdBreak(RdBreak), .FifoEmpty(FifoEmpty), .FifoFull(FifoFull),
    .FifoCount(FifoCount), .Overrun(Overrun), .OverrunClr(OverrunClr),
    .RxBusy(RxBusy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tx_bit(input logic b);
    Rxd = b;
    repeat (BIT_CLKS) @(negedge Clock);
  endtask

  // glitch selects a data bit that gets a one-clock inversion at its centre.
  task automatic send_frame(input logic [8:0] d, input int nbits, input bit pen,
                            input bit pbit, input int nstop, input bit stop_bad,
                            input int glitch);
    tx_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch) begin
        Rxd = d[i];
        repeat (8) @(negedge Clock);
        Rxd = ~d[i];
        @(negedge Clock);
        Rxd = d[i];
        repeat (7) @(negedge Clock);
      end else begin
        tx_bit(d[i]);
      end
    end
    if (pen) tx_bit(pbit);
    for (int s = 0; s < nstop; s++) tx_bit(stop_bad ? 1'b0 : 1'b1);
    Rxd = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200 && RxBusy; k++) @(negedge Clock);
    check(tag, RxBusy, 0);
  endtask

  task automatic pop();
    RdEn = 1'b1;
    @(negedge Clock);
    RdEn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge Clock);
    check("rst_empty", FifoEmpty, 1);
    check("rst_full", FifoFull, 0);
    check("rst_count", FifoCount, 0);
    check("rst_ovr", Overrun, 0);
    check("rst_busy", RxBusy, 0);
    check("rst_head", {RdBreak, RdFrameErr, RdParityErr, RdData}, 0);
    Reset = 1'b1;
    Enable = 1'b1;
    repeat (5) @(negedge Clock);

    // 8N1, 0xA5
    send_frame(9'h0A5, 8, 0, 0, 1, 0, -1);
    wait_idle("t1_idle");
    check("t1_data", RdData, 9'h0A5);
    check("t1_flags", {RdBreak, RdFrameErr, RdParityErr}, 0);
    check("t1_count", FifoCount, 1);
    pop();
    check("t1_empty", FifoEmpty, 1);

    // 9 data bits, even parity, 2 stop bits; 0x1C3 has five ones so parity bit is 1
    DataLenLimit = 4'd8; ParityEn = 1'b1; ParityPolarity = 1'b0; StopLenLimit = 1'b1;
    send_frame(9'h1C3, 9, 1, 1, 2, 0, -1);
    wait_idle("t2_idle_a");
    check("t2_data_a", RdData, 9'h1C3);
    check("t2_flags_a", {RdBreak, RdFrameErr, RdParityErr}, 0);
    pop();
    send_frame(9'h1C3, 9, 1, 0, 2, 0, -1);
    wait_idle("t2_idle_b");
    check("t2_data_b", RdData, 9'h1C3);
    check("t2_perr_b", RdParityErr, 1);
    check("t2_ferr_b", RdFrameErr, 0);
    pop();

    // false start and mid-bit glitch, back to 8N1
    DataLenLimit = 4'd7; ParityEn = 1'b0; StopLenLimit = 1'b0;
    Rxd = 1'b0;
    repeat (3) @(negedge Clock);
    Rxd = 1'b1;
    repeat (40) @(negedge Clock);
    check("t3_false_busy", RxBusy, 0);
    check("t3_false_empty", FifoEmpty, 1);
    send_frame(9'h055, 8, 0, 0, 1, 0, 3);
    wait_idle("t3_idle");
    check("t3_glitch_data", RdData, 9'h055);
    check("t3_glitch_flags", {RdBreak, RdFrameErr, RdParityErr}, 0);
    pop();

    // overrun with a 4-entry FIFO
    for (int i = 0; i < 5; i++) send_frame(9'(8'h11 + i), 8, 0, 0, 1, 0, -1);
    wait_idle("t4_idle");
    check("t4_count", FifoCount, 4);
    check("t4_full", FifoFull, 1);
    check("t4_ovr", Overrun, 1);
    for (int i = 0; i < 4; i++) begin
      check("t4_read", RdData, 32'h11 + i);
      pop();
    end
    check("t4_empty", FifoEmpty, 1);
    check("t4_ovr_held", Overrun, 1);
    OverrunClr = 1'b1;
    @(negedge Clock);
    OverrunClr = 1'b0;
    check("t4_ovr_clr", Overrun, 0);

    // break: 12 bit times low
    Rxd = 1'b0;
    repeat (12 * BIT_CLKS) @(negedge Clock);
    check("t5_count", FifoCount, 1);
    check("t5_brkwait", RxBusy, 1);
    check("t5_head", {RdBreak, RdFrameErr, RdData}, {2'b11, 9'h000});
    Rxd = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge Clock);
    check("t5_released", RxBusy, 0);
    check("t5_count_after", FifoCount, 1);
    pop();
    send_frame(9'h03C, 8, 0, 0, 1, 0, -1);
    wait_idle("t5_idle");
    check("t5_next_data", RdData, 9'h03C);
    check("t5_next_flags", {RdBreak, RdFrameErr, RdParityErr}, 0);
    pop();

    // stop bit low, then reset mid-frame
    send_frame(9'h07E, 8, 0, 0, 1, 1, -1);
    wait_idle("t6_idle");
    check("t6_data", RdData, 9'h07E);
    check("t6_ferr", RdFrameErr, 1);
    check("t6_brk", RdBreak, 0);
    check("t6_count", FifoCount, 1);
    tx_bit(1'b0);
    tx_bit(1'b1);
    tx_bit(1'b0);
    check("t6_midframe_busy", RxBusy, 1);
    Reset = 1'b0;
    Rxd = 1'b1;
    #1;
    check("t6_rst_empty", FifoEmpty, 1);
    check("t6_rst_count", FifoCount, 0);
    check("t6_rst_busy", RxBusy, 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check("t6_post_head", {RdBreak, RdFrameErr, RdParityErr, RdData}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver. It supports 5–9 data bits, majority-of-3 bit sampling, parity, 1–2 stop bits and break detection. A first-word-fall-through receive FIFO stores each frame with its per-frame error flags, and a sticky overrun flag records frames lost to a full FIFO. It sits between the Rxd pad and the peripheral bus register interface, which pops entries with RdEn.

Parameters:
BAUD_W, 16, width of BaudLimit and the baud counter.
FIFO_DEPTH, 8, number of FIFO entries; power of two, at least 2.
CNT_W, $clog2(FIFO_DEPTH)+1, width of FifoCount (derived; not overridden).

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Enable  in  1  1 = accept new start bits
DataLenLimit  in  4  data bits − 1; legal 4..8 (5..9 bits)
StopLenLimit  in  1  0 = 1 stop bit, 1 = 2 stop bits
ParityEn  in  1  1 = parity bit present
ParityPolarity  in  1  0 = even, 1 = odd
BaudLimit  in  BAUD_W  clocks per bit − 1; minimum 7
Rxd  in  1  asynchronous serial input, idles high
RdEn  in  1  pop FIFO head
RdData  out  9  head data, right-justified, unused upper bits 0
RdParityErr  out  1  head frame parity error
RdFrameErr  out  1  head frame stop-bit error
RdBreak  out  1  head frame is a break
FifoEmpty  out  1  FIFO empty
FifoFull  out  1  FIFO full
FifoCount  out  CNT_W  number of entries held
Overrun  out  1  sticky: a frame was dropped
OverrunClr  in  1  clears Overrun
RxBusy  out  1  receiver state is not IDLE

Behaviour:
- Reset values:
  - state IDLE; FIFO empty.
  - FifoEmpty = 1; FifoFull = 0; FifoCount = 0.
  - Overrun = 0; RxBusy = 0.
  - RdData and all Rd* flags = 0.
  - Synchroniser flops = 1.
- Reset mid-frame aborts the frame and discards all FIFO contents.
- Rxd passes through a 2-flop synchroniser, giving Rs. A falling edge of Rs in IDLE with Enable = 1 starts a frame. Edges are ignored when Enable = 0. Deasserting Enable mid-frame does not abort the frame in progress.
- Baud counter:
  - On start it loads BaudLimit >> 1 and counts down.
  - At 0 it reloads BaudLimit.
  - The cycle where the counter = 0 is the bit centre.
- Sampling: Rs is sampled at counter values 1, 0 and BaudLimit (three consecutive clocks). The bit value is the majority of the three samples. The decision is taken at counter = BaudLimit − 1.
- States: IDLE → START → DATA → [PARITY] → STOP → PUSH → IDLE. BRKWAIT is entered from PUSH.
  - START: majority 1 is a false start; return to IDLE, nothing pushed.
  - DATA: DataLenLimit + 1 bits, LSB first, assembled right-justified.
  - PARITY: error when XOR(data bits, parity bit, ParityPolarity) = 1. The error is recorded and the frame continues.
  - STOP: each stop bit is checked. A 0 sets the frame error and proceeds to PUSH immediately, without checking further stop bits. Otherwise PUSH follows after StopLenLimit + 1 good stop bits.
  - PUSH (1 cycle): writes {break, frame, parity, data} to the FIFO.
- Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0.
  - Entry stored with RdBreak = 1, RdFrameErr = 1, data = 0.
  - The state then goes to BRKWAIT until Rs = 1, then to IDLE. No further frames are received during BRKWAIT.
- FIFO write rules:
  - The write is accepted if not full, or if full and RdEn is asserted in the same cycle (count unchanged).
  - Otherwise the frame is dropped and Overrun is set from the next cycle.
  - If OverrunClr and a drop occur in the same cycle, set wins.
- FIFO read rules:
  - First-word fall-through: Rd* outputs show the head combinationally from registered storage and are forced to 0 when empty.
  - RdEn when empty is ignored.
  - Push into an empty FIFO: FifoEmpty falls the cycle after PUSH.
- Pointers wrap modulo FIFO_DEPTH. FifoCount = entries held; FifoFull when FifoCount = FIFO_DEPTH.
- Config inputs must stay stable while RxBusy = 1.
- RxBusy = 1 in every state except IDLE.

Test Plan:
1. BaudLimit = 15, 8N1, send 0xA5 → one entry: RdData = 0x0A5, all flags 0, FifoCount = 1. RdEn → FifoEmpty = 1.
2. 9 data bits, even parity, 2 stop bits, send 0x1C3 with correct parity → RdData = 0x1C3, no errors. Repeat with the parity bit flipped → RdParityErr = 1, data still 0x1C3.
3. 3-clock low pulse on idle Rxd → no entry, RxBusy returns to 0. A 1-clock glitch at the centre of data bit 3 of 0x55 → RdData = 0x055.
4. FIFO_DEPTH = 4, send 0x11..0x15 without reading → FifoCount = 4, FifoFull = 1, Overrun = 1. Reads return 0x11..0x14. OverrunClr → Overrun = 0.
5. Hold Rxd low for 12 bit times, 8N1 → exactly one entry: RdBreak = 1, RdFrameErr = 1, data 0. No new frame until Rxd goes high. 0x3C sent afterwards is received correctly.
6. Stop bit forced to 0 while sending 0x7E → RdFrameErr = 1, RdBreak = 0. Assert Reset mid-frame of the next byte → FIFO empty, RxBusy = 0.
